// File: rtl/instruction_fetch_queue_if.sv
// Fetch queue bus: instruction memory port, redirect input
// and the decode-side valid/ready handshake.
interface instruction_fetch_queue_if #(
    parameter int REG_BITS = 32
);
    logic [REG_BITS-1:0] imem_pc;
    logic [REG_BITS-1:0] imem_instruction;
    logic                redirect_valid;
    logic [REG_BITS-1:0] redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [REG_BITS-1:0] out_instruction;
    logic [REG_BITS-1:0] out_pc;

    modport master (
        output imem_pc,
        input  imem_instruction,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instruction,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Fetch stage: issues PCs to a registered-read imem and
// buffers {pc, instruction} pairs for decode; redirect flushes.
module instruction_fetch_queue #(
    parameter int                  REG_BITS = 32,
    parameter int                  DEPTH    = 4,
    parameter logic [REG_BITS-1:0] RESET_PC = '0
) (
    input logic                       clk,
    input logic                       rst_n,
    instruction_fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [REG_BITS-1:0] STEP = REG_BITS'(REG_BITS / 8);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [REG_BITS-1:0] r_fetch_pc;
    logic [REG_BITS-1:0] r_inflight_pc;
    logic                r_inflight;
    logic [REG_BITS-1:0] r_buf_pc  [DEPTH];
    logic [REG_BITS-1:0] r_buf_ins [DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_out_valid;
    logic [CW:0]         w_used;

    // Credit counts buffered entries plus the one in flight,
    // so a returning response always has a free slot.
    assign w_used      = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue     = !bus.redirect_valid && (w_used < DEPTH_C);
    assign w_push      = r_inflight && !bus.redirect_valid;
    assign w_out_valid = (r_count != '0) && !bus.redirect_valid;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign bus.imem_pc         = r_fetch_pc;
    assign bus.out_valid       = w_out_valid;
    assign bus.out_instruction = r_buf_ins[r_rptr];
    assign bus.out_pc          = r_buf_pc[r_rptr];

    // Fetch PC and in-flight tracking; redirect wins over issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= bus.redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc    <= r_fetch_pc + STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy; redirect empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf_pc[i]  <= '0;
                r_buf_ins[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (bus.redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_buf_pc[r_wptr]  <= r_inflight_pc;
                r_buf_ins[r_wptr] <= bus.imem_instruction;
                r_wptr            <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: 32-bit and
// 16-bit instances, each fed by a registered-read memory model.
module tb_instruction_fetch_queue;
    logic clk;
    logic rst_n;
    logic rst16_n;
    int   checks;
    int   failures;
    logic [31:0] exp32;
    logic [15:0] exp16;

    instruction_fetch_queue_if #(.REG_BITS(32)) b32 ();
    instruction_fetch_queue_if #(.REG_BITS(16)) b16 ();

    instruction_fetch_queue #(
        .REG_BITS(32), .DEPTH(4), .RESET_PC(32'h0)
    ) u32 (
        .clk(clk), .rst_n(rst_n), .bus(b32.master)
    );

    instruction_fetch_queue #(
        .REG_BITS(16), .DEPTH(4), .RESET_PC(16'h00FC)
    ) u16 (
        .clk(clk), .rst_n(rst16_n), .bus(b16.master)
    );

    // Memory byte at address a holds a[7:0]; words big-endian.
    function automatic logic [31:0] w32(input logic [31:0] a);
        logic [7:0] b0;
        b0 = a[7:0];
        return {b0, 8'(b0 + 8'd1), 8'(b0 + 8'd2), 8'(b0 + 8'd3)};
    endfunction

    function automatic logic [15:0] w16(input logic [15:0] a);
        logic [7:0] b0;
        b0 = a[7:0];
        return {b0, 8'(b0 + 8'd1)};
    endfunction

    always @(posedge clk) b32.imem_instruction <= w32(b32.imem_pc);
    always @(posedge clk) b16.imem_instruction <= w16(b16.imem_pc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic stream32(input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (b32.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL s32_valid: got %0b want 1", b32.out_valid);
            end
            checks++;
            if (b32.out_pc !== exp32) begin
                failures++;
                $display("FAIL s32_pc: got %0h want %0h", b32.out_pc, exp32);
            end
            checks++;
            if (b32.out_instruction !== w32(exp32)) begin
                failures++;
                $display("FAIL s32_ins: got %0h want %0h",
                         b32.out_instruction, w32(exp32));
            end
            exp32 = exp32 + 32'd4;
            cyc();
        end
    endtask

    task automatic stream16(input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (b16.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL s16_valid: got %0b want 1", b16.out_valid);
            end
            checks++;
            if (b16.out_pc !== exp16) begin
                failures++;
                $display("FAIL s16_pc: got %0h want %0h", b16.out_pc, exp16);
            end
            checks++;
            if (b16.out_instruction !== w16(exp16)) begin
                failures++;
                $display("FAIL s16_ins: got %0h want %0h",
                         b16.out_instruction, w16(exp16));
            end
            exp16 = exp16 + 16'd2;
            cyc();
        end
    endtask

    task automatic test_reset();
        chk("rst_imem_pc", b32.imem_pc, 32'h0);
        chk("rst_valid", 32'(b32.out_valid), 32'h0);
        chk("rst_ins", b32.out_instruction, 32'h0);
        chk("rst_pc", b32.out_pc, 32'h0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("c0_imem_pc", b32.imem_pc, 32'h0);
        cyc();
        chk("c1_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        chk("c2_valid", 32'(b32.out_valid), 32'h1);
        chk("c2_pc", b32.out_pc, 32'h0);
    endtask

    task automatic test_stream();
        exp32 = 32'h0;
        stream32(8);
    endtask

    task automatic test_backpressure();
        b32.out_ready = 1'b0;
        repeat (10) cyc();
        chk("bp_valid", 32'(b32.out_valid), 32'h1);
        chk("bp_head", b32.out_pc, exp32);
        chk("bp_count", 32'(u32.r_count), 32'h4);
        chk("bp_imem_pc", b32.imem_pc, exp32 + 32'd16);
        cyc();
        chk("bp_imem_hold", b32.imem_pc, exp32 + 32'd16);
        b32.out_ready = 1'b1;
        stream32(8);
    endtask

    task automatic test_redirect();
        chk("rd_count2", 32'(u32.r_count), 32'h2);
        b32.redirect_valid = 1'b1;
        b32.redirect_pc = 32'h40;
        #1;
        chk("rd_t_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        b32.redirect_valid = 1'b0;
        #1;
        chk("rd_t1_valid", 32'(b32.out_valid), 32'h0);
        chk("rd_t1_imem", b32.imem_pc, 32'h40);
        cyc();
        chk("rd_t2_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        exp32 = 32'h40;
        stream32(6);
    endtask

    task automatic test_back_to_back();
        chk("bb_count1", 32'(u32.r_count), 32'h1);
        b32.redirect_valid = 1'b1;
        b32.redirect_pc = 32'h80;
        #1;
        chk("bb_t_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        b32.redirect_pc = 32'hC0;
        #1;
        chk("bb_t1_valid", 32'(b32.out_valid), 32'h0);
        chk("bb_t1_imem", b32.imem_pc, 32'h80);
        cyc();
        b32.redirect_valid = 1'b0;
        #1;
        chk("bb_t2_imem", b32.imem_pc, 32'hC0);
        chk("bb_t2_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        chk("bb_t3_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        exp32 = 32'hC0;
        stream32(4);
    endtask

    task automatic test_async_reset();
        b32.out_ready = 1'b0;
        repeat (4) cyc();
        chk("ar_full", 32'(u32.r_count), 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(b32.out_valid), 32'h0);
        chk("ar_pc", b32.out_pc, 32'h0);
        chk("ar_ins", b32.out_instruction, 32'h0);
        chk("ar_imem", b32.imem_pc, 32'h0);
        chk("ar_count", 32'(u32.r_count), 32'h0);
        cyc();
        rst_n = 1'b1;
        b32.out_ready = 1'b1;
        #1;
        chk("ar_c0_imem", b32.imem_pc, 32'h0);
        cyc();
        chk("ar_c1_valid", 32'(b32.out_valid), 32'h0);
        cyc();
        exp32 = 32'h0;
        stream32(4);
    endtask

    task automatic test_reg16();
        rst16_n = 1'b1;
        #1;
        chk("r16_c0_imem", 32'(b16.imem_pc), 32'hFC);
        cyc();
        chk("r16_c1_valid", 32'(b16.out_valid), 32'h0);
        cyc();
        exp16 = 16'h00FC;
        stream16(4);
        b16.redirect_valid = 1'b1;
        b16.redirect_pc = 16'hFFFC;
        #1;
        chk("r16_rd_valid", 32'(b16.out_valid), 32'h0);
        cyc();
        b16.redirect_valid = 1'b0;
        #1;
        chk("r16_rd_imem", 32'(b16.imem_pc), 32'hFFFC);
        cyc();
        cyc();
        exp16 = 16'hFFFC;
        stream16(4);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        rst16_n = 1'b0;
        b32.out_ready = 1'b1;
        b32.redirect_valid = 1'b0;
        b32.redirect_pc = '0;
        b16.out_ready = 1'b1;
        b16.redirect_valid = 1'b0;
        b16.redirect_pc = '0;
        #12;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_async_reset();
        test_reg16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch stage that drives the program counter into the instruction memory and buffers returned instructions for decode. The instruction memory has a registered read: it samples the PC on `clk` and presents the instruction one cycle later. This block issues one fetch per cycle when credit allows, captures each returned instruction with its PC into a DEPTH-entry FIFO, and hands entries to decode over a valid/ready handshake. A branch/jump redirect flushes all buffered and in-flight work.

## Interface
- `REG_BITS`, 32: instruction/PC width. Only 32 and 16 are legal. STEP = REG_BITS/8 bytes per instruction (4 or 2).
- `DEPTH`, 4: FIFO entries. Must be a power of 2 and ≥ 2.
- `RESET_PC`, 0: PC loaded on reset.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `imem_pc`  out  REG_BITS: address to instruction memory; equals the `fetch_pc` register.
- `imem_instruction`  in  REG_BITS: memory read data, valid for the PC presented in the previous cycle.
- `redirect_valid`  in  1: redirect request from branch/jump resolution.
- `redirect_pc`  in  REG_BITS: new fetch address, used unmodified.
- `out_valid`  out  1: FIFO head is valid for decode.
- `out_ready`  in  1: decode accepts the head.
- `out_instruction`  out  REG_BITS: head instruction.
- `out_pc`  out  REG_BITS: PC of the head instruction.

## Operation
- **State:**
  - `fetch_pc`
  - `inflight` (1 bit) and `inflight_pc`
  - FIFO storage of {pc, instruction}, with read/write pointers and `count` (0..DEPTH)
- **Reset (async, `rst_n`=0):**
  - `fetch_pc`=RESET_PC; `inflight`=0; `inflight_pc`=0; pointers=0; `count`=0; FIFO contents=0.
  - Outputs: `imem_pc`=RESET_PC, `out_valid`=0, `out_instruction`=0, `out_pc`=0.
  - Reset asserted mid-operation discards everything immediately.
- **Issue:** `issue` = !`redirect_valid` && (`count` + `inflight` < DEPTH).
  - On issue: `fetch_pc` += STEP (mod 2^REG_BITS), `inflight`←1, `inflight_pc`←`fetch_pc`.
  - Otherwise `inflight`←0 and `fetch_pc` holds.
- **Capture:** if `inflight`=1 and !`redirect_valid`, push {`inflight_pc`, `imem_instruction`} at the write pointer. The credit rule guarantees the FIFO is never full on a push.
- **Output:**
  - `out_valid` = (`count`≠0) && !`redirect_valid`.
  - `out_instruction`/`out_pc` = head entry (combinational read).
  - Pop when `out_valid` && `out_ready`.
- **Push and pop in the same cycle:** `count` unchanged, both pointers advance.
- **Redirect** (`redirect_valid`=1 in a cycle):
  - `fetch_pc`←`redirect_pc`, `inflight`←0, `count`←0, pointers←0.
  - The response arriving that cycle is dropped, and no pop occurs.
  - Redirect has priority over every other event.
- **Pointers:** wrap modulo DEPTH.
- **PC range:** the full REG_BITS range is passed through; range checking is the memory's concern.

## Timing
- Issue-to-`out_valid` latency: 2 cycles. PC on `imem_pc` in cycle t → instruction captured at the end of t+1 → `out_valid` in t+2.
- **After reset release:** cycle 0 `imem_pc`=RESET_PC; cycle 2 first `out_valid`=1 with `out_pc`=RESET_PC.
- **Throughput:** with `out_ready` held at 1, one instruction per cycle; `count` settles at 1 and `inflight` at 1.
- **Back-pressure:** with `out_ready`=0, issues stop once `count`+`inflight`=DEPTH. The FIFO then fills to exactly DEPTH. `imem_pc` holds the next unfetched PC, and no instruction is lost or duplicated.
- **Redirect in cycle t:**
  - `out_valid`=0 in t and t+1.
  - `imem_pc`=`redirect_pc` in t+1.
  - `out_valid`=1 with `out_pc`=`redirect_pc` in t+3 at the earliest.
- **Back-to-back redirects:** the last one wins; each restarts the 2-cycle latency.
- No combinational path from `out_ready` to `imem_pc`. `redirect_valid` reaches `out_valid` combinationally.

## Test plan
- **Reset start, REG_BITS=32, RESET_PC=0, `out_ready`=1, memory loaded with sequential words:** `out_pc` = 0,4,8,12… on consecutive cycles from cycle 2. `out_instruction` matches memory bytes big-endian.
- **Back-pressure:** after the stream starts, hold `out_ready`=0 for 10 cycles. `count` reaches 4 and `imem_pc` freezes. On release, PCs continue with no gap or duplicate.
- **Redirect mid-stream to 0x40 while the FIFO holds 2 entries:**
  - `out_valid`=0 for 2 cycles, then `out_pc`=0x40, 0x44…
  - No pre-redirect entry appears after the redirect cycle.
- **Redirect in the same cycle as `out_ready`=1 with `count`=1:** no pop counted, and the entry never reappears. Also apply redirects on two consecutive cycles (0x80 then 0xC0): the stream resumes at 0xC0.
- **Async reset mid-operation:** assert `rst_n`=0 between clock edges with a full FIFO. All outputs go to reset values immediately; after release the stream restarts at RESET_PC.
- **REG_BITS=16, RESET_PC=0xFC:** PCs step 0xFC, 0xFE, 0x100…. Also redirect to 0xFFFC with REG_BITS=16: the stream runs 0xFFFC, 0xFFFE, then 0x0000 (wrap).
